// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO pair.
// Results are computed at launch and committed after a fixed latency.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

    state_t           state, state_n;
    logic [3:0]       cnt, cnt_n;
    logic [WIDTH-1:0] pend_hi, pend_hi_n;
    logic [WIDTH-1:0] pend_lo, pend_lo_n;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic             done_n;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   mag_a, mag_b, div_b;
    logic [WIDTH-1:0]   uq, ur, sq, sr;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // Combinational arithmetic on the launch operands
    always_comb begin
        prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        mag_a  = a[WIDTH-1] ? -a : a;
        mag_b  = b[WIDTH-1] ? -b : b;
        // Signed division works on magnitudes, so MIN / -1 needs no trap
        div_b  = (mag_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
        sq     = mag_a / div_b;
        sr     = mag_a % div_b;
        if (a[WIDTH-1] ^ b[WIDTH-1]) sq = -sq;
        if (a[WIDTH-1]) sr = -sr;
        div_b  = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
        uq     = a / div_b;
        ur     = a % div_b;
        res_hi = '0;
        res_lo = '0;
        case (op)
            3'd0: begin
                res_hi = prod_s[2*WIDTH-1:WIDTH];
                res_lo = prod_s[WIDTH-1:0];
            end
            3'd1: begin
                res_hi = prod_u[2*WIDTH-1:WIDTH];
                res_lo = prod_u[WIDTH-1:0];
            end
            3'd2: begin
                res_hi = (b == '0) ? a : sr;
                res_lo = (b == '0) ? '1 : sq;
            end
            3'd3: begin
                res_hi = (b == '0) ? a : ur;
                res_lo = (b == '0) ? '1 : uq;
            end
            default: ;
        endcase
    end

    // Next-state, counter and HI/LO update logic
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pend_hi_n = pend_hi;
        pend_lo_n = pend_lo;
        hi_n      = hi;
        lo_n      = lo;
        done_n    = 1'b0;
        unique case (state)
            RUN: begin
                cnt_n = cnt - 4'd1;
                if (cancel) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == 4'd1) begin
                    state_n = IDLE;
                    hi_n    = pend_hi;
                    lo_n    = pend_lo;
                    done_n  = 1'b1;
                end
            end
            default: begin
                if (start && !cancel) begin
                    unique case (1'b1)
                        (op[2] == 1'b0): begin
                            pend_hi_n = res_hi;
                            pend_lo_n = res_lo;
                            cnt_n     = op[1] ? DIV_LAT : MULT_LAT;
                            state_n   = RUN;
                        end
                        (op == 3'd4): hi_n = a;
                        (op == 3'd5): lo_n = a;
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // State and register update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pend_hi <= pend_hi_n;
            pend_lo <= pend_lo_n;
            hi      <= hi_n;
            lo      <= lo_n;
            done    <= done_n;
        end
    end

    assign busy = (state == RUN);

endmodule
